jump_ctrl: RTL

Branch/jump resolution unit that drives the program counter's jump_en/target inputs. Each cycle it takes the decoded control op of the instruction at prog_ctr and returns the relative offset to apply. Inputs are the stored zero flag, a 16-entry programmable offset table and a small return-address stack. It sits between the decoder and the PC and owns all control-flow state: flag, offset LUT, call stack, halt and error status.

---
 rtl/jump_ctrl_if.sv | 35 +++
 rtl/jump_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/jump_ctrl_if.sv
// jump_ctrl_if: decoder/PC-side bus of the branch resolution unit.
//   prog_ctr, op, lut_idx      : instruction being resolved this cycle
//   flag_z, flag_we            : zero-flag capture
//   lut_we, lut_waddr, lut_wdata : offset table programming
//   jump_en, target            : combinational jump request to the PC
//   done, stk_ovf, stk_unf     : registered status
// master = decoder/PC side, slave = jump_ctrl.
interface jump_ctrl_if #(
    parameter int D      = 12,
    parameter int LUT_AW = 4
);
    logic [D-1:0]      prog_ctr;
    logic [2:0]        op;
    logic [LUT_AW-1:0] lut_idx;
    logic              flag_z;
    logic              flag_we;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [D-1:0]      lut_wdata;
    logic              jump_en;
    logic [D-1:0]      target;
    logic              done;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output prog_ctr, op, lut_idx, flag_z, flag_we, lut_we, lut_waddr, lut_wdata,
        input  jump_en, target, done, stk_ovf, stk_unf
    );

    modport slave (
        input  prog_ctr, op, lut_idx, flag_z, flag_we, lut_we, lut_waddr, lut_wdata,
        output jump_en, target, done, stk_ovf, stk_unf
    );
endinterface

// File: rtl/jump_ctrl.sv
// jump_ctrl: branch/jump resolution unit. Resolves the op at prog_ctr into a
// relative PC offset (jump_en/target, combinational) and owns all control-flow
// state: zero flag, programmable offset table, return-address stack, halt and
// stack error status.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : jump_ctrl_if.slave (see interface header)
module jump_ctrl #(
    parameter int D         = 12,
    parameter int LUT_AW    = 4,
    parameter int STK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    jump_ctrl_if.slave bus
);
    localparam int SPW   = $clog2(STK_DEPTH + 1);
    localparam int LUT_N = 1 << LUT_AW;
    // Stack storage is rounded up to a power of two so sp-1 indexes it
    // without width juggling; entries >= STK_DEPTH are never written.
    localparam int STK_N = 1 << SPW;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STK_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_BZ   = 3'b001,
        OP_BNZ  = 3'b010,
        OP_JMP  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101,
        OP_HALT = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    state_e         state, state_nxt;
    logic           zf;
    logic [D-1:0]   lut [LUT_N];
    logic [D-1:0]   stk [STK_N];
    logic [SPW-1:0] sp;
    logic           ovf_q, unf_q;

    logic           jen;
    logic [D-1:0]   tgt;
    logic           push, pop, set_ovf, set_unf;
    logic           live;
    logic [D-1:0]   lut_rd, stk_top;

    // Reads see pre-edge contents, so same-cycle writes return old data.
    assign lut_rd  = lut[bus.lut_idx];
    assign stk_top = stk[sp - SPW'(1)];

    // Flag/LUT writes only take effect while running and out of reset.
    assign live = !reset && (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            zf    <= 1'b0;
            sp    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else begin
            state <= state_nxt;
            if (live && bus.flag_we) zf <= bus.flag_z;
            if (live && bus.lut_we)  lut[bus.lut_waddr] <= bus.lut_wdata;
            if (push) begin
                stk[sp] <= bus.prog_ctr + D'(1);
                sp      <= sp + SPW'(1);
            end else if (pop) begin
                sp <= sp - SPW'(1);
            end
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        jen       = 1'b0;
        tgt       = '0;
        push      = 1'b0;
        pop       = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (!reset) begin
            if (state == ST_HALT) begin
                // Halted: every op holds the PC, no side effects.
                jen = 1'b1;
            end else begin
                case (op_e'(bus.op))
                    OP_BZ: if (zf) begin
                        jen = 1'b1;
                        tgt = lut_rd;
                    end
                    OP_BNZ: if (!zf) begin
                        jen = 1'b1;
                        tgt = lut_rd;
                    end
                    OP_JMP: begin
                        jen = 1'b1;
                        tgt = lut_rd;
                    end
                    OP_CALL: begin
                        // Jump is taken even when the push has to be dropped.
                        jen = 1'b1;
                        tgt = lut_rd;
                        if (sp == SP_FULL) set_ovf = 1'b1;
                        else               push    = 1'b1;
                    end
                    OP_RET: begin
                        if (sp != '0) begin
                            jen = 1'b1;
                            tgt = stk_top - bus.prog_ctr;
                            pop = 1'b1;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        jen       = 1'b1;
                        state_nxt = ST_HALT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.jump_en = jen;
    assign bus.target  = tgt;
    assign bus.done    = (state == ST_HALT);
    assign bus.stk_ovf = ovf_q;
    assign bus.stk_unf = unf_q;
endmodule
